pa_cp0_cpuid_reader: RTL and testbench
======================================

Name: pa_cp0_cpuid_reader

Overview:
- Initiator side of the mcpuid CSR read protocol.
- On a start pulse it issues back-to-back mcpuid reads. Each read auto-advances the responder's rotating index (0→1→2→0).
- It aligns on the tag field [31:28], collects all three index words, and presents them plus decoded fields.
- Sits in cp0 beside the info CSR block and feeds debug/boot-info snapshot logic.

Parameters:
- ACK_TIMEOUT, 16, max cycles csr_rd_req may wait for csr_rd_ack before aborting (≥2).
- TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- regs_clk  in  1  clock.
- cpurst_b  in  1  synchronous active-low reset.
- rdr_start  in  1  one-cycle start request.
- rdr_busy  out  1  high while a collection is in progress.
- rdr_done  out  1  one-cycle pulse at completion (success or error).
- rdr_err  out  1  level; error status of the last collection.
- rdr_err_code  out  2  01 bad tag, 10 sequence break, 11 ack timeout, 00 none.
- csr_rd_req  out  1  mcpuid read request; held until acked.
- csr_rd_ack  in  1  read accepted; csr_rd_data valid in the same cycle.
- csr_rd_data  in  32  mcpuid read value.
- cpuid_valid  out  1  level; all three words captured, no error.
- cpuid_word0/1/2  out  32 each  captured index words.
- cpuid_arch  out  2  word0[27:26].
- cpuid_family  out  4  word0[25:22].
- cpuid_class  out  4  word0[21:18].
- cpuid_rev  out  4  word1[27:24].
- cpuid_product  out  12  word1[11:0].
- cpuid_pmp  out  3  word2[5:3].

Behaviour:
- Reset, applied synchronously when cpurst_b is low at a regs_clk edge:
  - State goes to IDLE.
  - All outputs, the words, the slot-valid bits, the counters and the last tag go to 0.
  - csr_rd_req deasserts at that same edge, so any outstanding read is abandoned.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - rdr_start=1 moves the FSM to REQ.
  - On that transition, clear cpuid_valid, rdr_err, rdr_err_code, the slot-valid bits, the timeout counter and the first-read flag.
  - The words keep their old values until overwritten.
- REQ:
  - csr_rd_req=1 and rdr_busy=1.
  - Each cycle with ack=0, the timeout counter increments.
  - When the counter reaches ACK_TIMEOUT-1 with ack still 0, set err code 11 and go to DONE.
- On ack in REQ, let tag = csr_rd_data[31:28]:
  - If tag > 2: err code 01, go to DONE.
  - Else if this is not the first read and tag != (last_tag==2 ? 0 : last_tag+1): err code 10, go to DONE.
  - Else: store the data into slot[tag], set slot-valid[tag], record last_tag, and clear the timeout counter.
  - If all three slot-valid bits are now set, go to DONE with no error.
  - Otherwise stay in REQ; csr_rd_req stays high for the next read (back-to-back, one read per ack).
- The first read may return any tag 0..2. A collection therefore always finishes in exactly 3 acks when there is no error.
- DONE:
  - Lasts one cycle: rdr_done=1, rdr_busy=0, csr_rd_req=0.
  - Set cpuid_valid=1 if there is no error; otherwise set rdr_err=1.
  - Then return to IDLE.
- rdr_start while in REQ or DONE is ignored; it is not queued.
- csr_rd_ack while csr_rd_req=0 is ignored.
- Decoded field outputs are combinational slices of the stored words. They are valid only when cpuid_valid=1.
- Timeout counter: saturating, width TO_W, no wrap. Latency from rdr_start to rdr_done with an immediate ack each cycle is 5 cycles.

Decomposition:
- A shared cp0 package holds:
  - the state encoding;
  - the tag constants 0/1/2 and TAG_MAX=2;
  - the error-code constants;
  - the field bit positions (ARCH 27:26, FAMILY 25:22, CLASS 21:18, REV 27:24, PRODUCT 11:0, PMP 5:3).
- One natural sub-module, pa_cp0_cpuid_decode: a combinational field slicer from the three words.
- The FSM, counter and capture registers stay in the top module.

Test Plan:
- Responder model at index 0 returns 0x0810010D, 0x11000ABC, 0x252BF93B with ack each cycle → rdr_done 5 cycles after start, cpuid_valid=1, arch=2, class=4, product=0xABC, pmp=7, err=0.
- Responder starting at index 1 returns 0x11000ABC, 0x252BF93B, 0x0810010D → identical words, success after 3 acks.
- Second read returns tag 3 (0x3000_0000) → rdr_done, rdr_err=1, code 01, cpuid_valid=0, csr_rd_req low after DONE.
- Reads return tag 0 then tag 2 → code 10 on the second ack, no third request issued.
- ack never asserted → after 16 cycles of req, rdr_done with code 11; rdr_start pulses during busy are ignored.
- cpurst_b=0 one cycle mid-collection after 1 ack → next edge csr_rd_req=0, busy=0, all outputs 0; a new start then succeeds normally.

Source files
------------

// File: rtl/pa_cp0_cpuid_reader_pkg.sv
// Shared cp0 definitions for the mcpuid reader: FSM encoding, tag and error
// constants, and the bit positions of the decoded cpuid fields.
package pa_cp0_cpuid_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } rdr_state_e;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned TAG_LSB   = 28;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned NUM_SLOTS = 3;

  localparam logic [IDX_W-1:0] TAG_0   = 2'd0;
  localparam logic [IDX_W-1:0] TAG_1   = 2'd1;
  localparam logic [IDX_W-1:0] TAG_2   = 2'd2;
  localparam logic [TAG_W-1:0] TAG_MAX = 4'd2;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_TAG = 2'b01;
  localparam logic [1:0] ERR_SEQ     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int unsigned ARCH_LSB    = 26;
  localparam int unsigned ARCH_W      = 2;
  localparam int unsigned FAMILY_LSB  = 22;
  localparam int unsigned FAMILY_W    = 4;
  localparam int unsigned CLASS_LSB   = 18;
  localparam int unsigned CLASS_W     = 4;
  localparam int unsigned REV_LSB     = 24;
  localparam int unsigned REV_W       = 4;
  localparam int unsigned PRODUCT_LSB = 0;
  localparam int unsigned PRODUCT_W   = 12;
  localparam int unsigned PMP_LSB     = 3;
  localparam int unsigned PMP_W       = 3;

  // Responder index rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [IDX_W-1:0] next_tag(input logic [IDX_W-1:0] tag);
    return (tag == TAG_2) ? TAG_0 : tag + IDX_W'(1);
  endfunction

endpackage

// File: rtl/pa_cp0_cpuid_decode.sv
// Combinational field slicer over the three captured mcpuid index words.
// Fields are meaningful only while the reader reports cpuid_valid.
module pa_cp0_cpuid_decode
  import pa_cp0_cpuid_reader_pkg::*;
(
  input  logic [WORD_W-1:0]    word0,
  input  logic [WORD_W-1:0]    word1,
  input  logic [WORD_W-1:0]    word2,
  output logic [ARCH_W-1:0]    arch,
  output logic [FAMILY_W-1:0]  family,
  output logic [CLASS_W-1:0]   cls,
  output logic [REV_W-1:0]     rev,
  output logic [PRODUCT_W-1:0] product,
  output logic [PMP_W-1:0]     pmp
);

  logic unused_bits;

  assign arch    = word0[ARCH_LSB +: ARCH_W];
  assign family  = word0[FAMILY_LSB +: FAMILY_W];
  assign cls     = word0[CLASS_LSB +: CLASS_W];
  assign rev     = word1[REV_LSB +: REV_W];
  assign product = word1[PRODUCT_LSB +: PRODUCT_W];
  assign pmp     = word2[PMP_LSB +: PMP_W];

  // Remaining word bits (tags, reserved fields) are not decoded here.
  assign unused_bits = ^{word0, word1, word2};

endmodule

// File: rtl/pa_cp0_cpuid_reader.sv
// mcpuid read initiator: issues back-to-back reads on start, aligns on the
// rotating index tag, captures all three words and reports success or error.
module pa_cp0_cpuid_reader
  import pa_cp0_cpuid_reader_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        regs_clk,
  input  logic        cpurst_b,
  input  logic        rdr_start,
  output logic        rdr_busy,
  output logic        rdr_done,
  output logic        rdr_err,
  output logic [1:0]  rdr_err_code,
  output logic        csr_rd_req,
  input  logic        csr_rd_ack,
  input  logic [31:0] csr_rd_data,
  output logic        cpuid_valid,
  output logic [31:0] cpuid_word0,
  output logic [31:0] cpuid_word1,
  output logic [31:0] cpuid_word2,
  output logic [1:0]  cpuid_arch,
  output logic [3:0]  cpuid_family,
  output logic [3:0]  cpuid_class,
  output logic [3:0]  cpuid_rev,
  output logic [11:0] cpuid_product,
  output logic [2:0]  cpuid_pmp
);

  rdr_state_e           state_q, state_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [NUM_SLOTS-1:0] slot_vld_q, slot_vld_d;
  logic [IDX_W-1:0]     last_tag_q, last_tag_d;
  logic                 rd_seen_q, rd_seen_d;
  logic [WORD_W-1:0]    word0_q, word0_d;
  logic [WORD_W-1:0]    word1_q, word1_d;
  logic [WORD_W-1:0]    word2_q, word2_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 req_q, req_d;

  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     tag_idx;
  logic [NUM_SLOTS-1:0] slot_new;
  logic                 fin;
  logic [1:0]           fin_code;

  assign tag     = csr_rd_data[TAG_LSB +: TAG_W];
  assign tag_idx = tag[IDX_W-1:0];

  // State and capture registers.
  always_ff @(posedge regs_clk) begin
    if (!cpurst_b) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= '0;
      slot_vld_q <= '0;
      last_tag_q <= '0;
      rd_seen_q  <= 1'b0;
      word0_q    <= '0;
      word1_q    <= '0;
      word2_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      slot_vld_q <= slot_vld_d;
      last_tag_q <= last_tag_d;
      rd_seen_q  <= rd_seen_d;
      word0_q    <= word0_d;
      word1_q    <= word1_d;
      word2_q    <= word2_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
    end
  end

  // Next state, timeout counting and word capture.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    slot_vld_d = slot_vld_q;
    last_tag_d = last_tag_q;
    rd_seen_d  = rd_seen_q;
    word0_d    = word0_q;
    word1_d    = word1_q;
    word2_d    = word2_q;
    valid_d    = valid_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    slot_new   = slot_vld_q;
    fin        = 1'b0;
    fin_code   = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (rdr_start) begin
          state_d    = ST_REQ;
          valid_d    = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          slot_vld_d = '0;
          to_cnt_d   = '0;
          rd_seen_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (csr_rd_ack) begin
          if (tag > TAG_MAX) begin
            fin      = 1'b1;
            fin_code = ERR_BAD_TAG;
          end else if (rd_seen_q && (tag_idx != next_tag(last_tag_q))) begin
            fin      = 1'b1;
            fin_code = ERR_SEQ;
          end else begin
            case (tag_idx)
              TAG_0:   word0_d = csr_rd_data;
              TAG_1:   word1_d = csr_rd_data;
              TAG_2:   word2_d = csr_rd_data;
              default: ;
            endcase
            slot_new   = slot_vld_q | (NUM_SLOTS'(1) << tag_idx);
            slot_vld_d = slot_new;
            last_tag_d = tag_idx;
            rd_seen_d  = 1'b1;
            to_cnt_d   = '0;
            fin        = &slot_new;
          end
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status for the DONE cycle is latched on the way in.
    if (fin) begin
      state_d    = ST_DONE;
      err_code_d = fin_code;
      err_d      = (fin_code != ERR_NONE);
      valid_d    = (fin_code == ERR_NONE);
    end
  end

  // Handshake outputs decoded from the upcoming state so they are registered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    req_d  = 1'b0;
    case (state_d)
      ST_REQ: begin
        busy_d = 1'b1;
        req_d  = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign rdr_busy     = busy_q;
  assign rdr_done     = done_q;
  assign rdr_err      = err_q;
  assign rdr_err_code = err_code_q;
  assign csr_rd_req   = req_q;
  assign cpuid_valid  = valid_q;
  assign cpuid_word0  = word0_q;
  assign cpuid_word1  = word1_q;
  assign cpuid_word2  = word2_q;

  pa_cp0_cpuid_decode u_decode (
    .word0   (word0_q),
    .word1   (word1_q),
    .word2   (word2_q),
    .arch    (cpuid_arch),
    .family  (cpuid_family),
    .cls     (cpuid_class),
    .rev     (cpuid_rev),
    .product (cpuid_product),
    .pmp     (cpuid_pmp)
  );

endmodule

// File: tb/tb_pa_cp0_cpuid_reader.sv
// Bench for pa_cp0_cpuid_reader: a queue-driven mcpuid responder plus a
// tag-walk reference model that predicts outcome, ack count and stored words.
module tb_pa_cp0_cpuid_reader;

  localparam logic [31:0] W0 = 32'h0810010D;
  localparam logic [31:0] W1 = 32'h11000ABC;
  localparam logic [31:0] W2 = 32'h252BF93B;

  logic        regs_clk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        rdr_start = 1'b0;
  logic        csr_rd_ack = 1'b0;
  logic [31:0] csr_rd_data = '0;
  logic        rdr_busy, rdr_done, rdr_err, csr_rd_req, cpuid_valid;
  logic [1:0]  rdr_err_code, cpuid_arch;
  logic [31:0] cpuid_word0, cpuid_word1, cpuid_word2;
  logic [3:0]  cpuid_family, cpuid_class, cpuid_rev;
  logic [11:0] cpuid_product;
  logic [2:0]  cpuid_pmp;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rsp_q[$];
  int          max_gap = 0;
  int          gap_cnt = 0;
  int          n_acks = 0;
  bit          stray_ack = 1'b0;
  logic [31:0] mdl_word[3];

  pa_cp0_cpuid_reader #(.ACK_TIMEOUT(16), .TO_W(5)) dut (
    .regs_clk      (regs_clk),
    .cpurst_b      (cpurst_b),
    .rdr_start     (rdr_start),
    .rdr_busy      (rdr_busy),
    .rdr_done      (rdr_done),
    .rdr_err       (rdr_err),
    .rdr_err_code  (rdr_err_code),
    .csr_rd_req    (csr_rd_req),
    .csr_rd_ack    (csr_rd_ack),
    .csr_rd_data   (csr_rd_data),
    .cpuid_valid   (cpuid_valid),
    .cpuid_word0   (cpuid_word0),
    .cpuid_word1   (cpuid_word1),
    .cpuid_word2   (cpuid_word2),
    .cpuid_arch    (cpuid_arch),
    .cpuid_family  (cpuid_family),
    .cpuid_class   (cpuid_class),
    .cpuid_rev     (cpuid_rev),
    .cpuid_product (cpuid_product),
    .cpuid_pmp     (cpuid_pmp)
  );

  always #5 regs_clk = ~regs_clk;

  // Responder: pops one queued word per ack while req is up, optional gaps;
  // may toggle ack with junk data while req is low.
  always @(posedge regs_clk) begin
    #1;
    if (csr_rd_req === 1'b1 && rsp_q.size() > 0 && gap_cnt == 0) begin
      csr_rd_ack  = 1'b1;
      csr_rd_data = rsp_q.pop_front();
      n_acks++;
      gap_cnt = $urandom_range(max_gap, 0);
    end else begin
      if (csr_rd_req === 1'b1 && gap_cnt > 0) gap_cnt--;
      csr_rd_ack  = (stray_ack && csr_rd_req !== 1'b1) ? 1'($urandom_range(1, 0)) : 1'b0;
      csr_rd_data = $urandom;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Walks the returned words by the tag rules; updates the expected word store.
  task automatic model_run(input logic [31:0] seq[$], output logic [1:0] code, output int acks);
    int t;
    int prev;
    bit [2:0] filled;
    code = 2'b11; acks = 0; prev = -1; filled = '0;
    foreach (seq[k]) begin
      t = int'(seq[k][31:28]);
      acks++;
      if (t > 2) begin code = 2'b01; return; end
      if (prev >= 0 && t != (prev + 1) % 3) begin code = 2'b10; return; end
      mdl_word[t] = seq[k];
      filled[t] = 1'b1;
      prev = t;
      if (filled == 3'b111) begin code = 2'b00; return; end
    end
  endtask

  // Pulses start and follows the collection to rdr_done (bounded).
  task automatic collect(input bit noise, output int done_cyc, output int req_cyc,
                         output bit busy_bad, output bit hung, output bit done_long);
    busy_bad = 1'b0; hung = 1'b1; done_cyc = 0; req_cyc = 0; done_long = 1'b0;
    gap_cnt = 0; n_acks = 0;
    @(posedge regs_clk); #1; rdr_start = 1'b1;
    @(posedge regs_clk); #1; rdr_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rdr_busy !== csr_rd_req) busy_bad = 1'b1;
      if (rdr_done === 1'b1) begin hung = 1'b0; done_cyc = i + 2; break; end
      if (csr_rd_req === 1'b1) req_cyc++;
      rdr_start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      @(posedge regs_clk); #1;
    end
    rdr_start = 1'b0;
    if (!hung) begin
      @(posedge regs_clk); #1;
      done_long = rdr_done || csr_rd_req || rdr_busy;
    end
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0;
    repeat (3) @(posedge regs_clk);
    #1;
    n_cmp++;
    if ({rdr_busy, rdr_done, rdr_err, rdr_err_code, csr_rd_req, cpuid_valid} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b want=0", {rdr_busy, rdr_done, rdr_err, rdr_err_code, csr_rd_req, cpuid_valid});
    end
    n_cmp++;
    if ({cpuid_word0, cpuid_word1, cpuid_word2} !== 96'b0) begin
      n_bad++;
      $display("FAIL reset_words got=%h %h %h want=0", cpuid_word0, cpuid_word1, cpuid_word2);
    end
    n_cmp++;
    if ({cpuid_arch, cpuid_family, cpuid_class, cpuid_rev, cpuid_product, cpuid_pmp} !== 29'b0) begin
      n_bad++;
      $display("FAIL reset_fields got=%h want=0", {cpuid_arch, cpuid_family, cpuid_class, cpuid_rev, cpuid_product, cpuid_pmp});
    end
    cpurst_b = 1'b1;
    mdl_word = '{default: '0};
  endtask

  task automatic test_basic();
    int dc, rc; bit bb, hung, dl;
    max_gap = 0;
    rsp_q = '{W0, W1, W2};
    collect(1'b0, dc, rc, bb, hung, dl);
    n_cmp++;
    if (hung) begin n_bad++; $display("FAIL basic_hang got=no_done want=done"); end
    n_cmp++;
    if (dc != 5) begin n_bad++; $display("FAIL basic_latency got=%0d want=5", dc); end
    n_cmp++;
    if ({cpuid_valid, rdr_err, rdr_err_code} !== 4'b1000) begin
      n_bad++; $display("FAIL basic_status got=%b want=1000", {cpuid_valid, rdr_err, rdr_err_code});
    end
    n_cmp++;
    if ({cpuid_word0, cpuid_word1, cpuid_word2} !== {W0, W1, W2}) begin
      n_bad++; $display("FAIL basic_words got=%h %h %h", cpuid_word0, cpuid_word1, cpuid_word2);
    end
    n_cmp++;
    if ({cpuid_arch, cpuid_class, cpuid_product, cpuid_pmp} !== {2'd2, 4'd4, 12'hABC, 3'd7}) begin
      n_bad++; $display("FAIL basic_fields got=%h want=%h", {cpuid_arch, cpuid_class, cpuid_product, cpuid_pmp},
                        {2'd2, 4'd4, 12'hABC, 3'd7});
    end
    n_cmp++;
    if ({cpuid_family, cpuid_rev} !== {4'd0, 4'd1}) begin
      n_bad++; $display("FAIL basic_family_rev got=%h want=01", {cpuid_family, cpuid_rev});
    end
    n_cmp++;
    if (n_acks != 3 || bb || dl) begin
      n_bad++; $display("FAIL basic_handshake acks=%0d busy_bad=%0b done_long=%0b want 3/0/0", n_acks, bb, dl);
    end
    rsp_q.delete();
  endtask

  task automatic test_rotated();
    int dc, rc; bit bb, hung, dl;
    max_gap = 0;
    rsp_q = '{W1, W2, W0};
    collect(1'b0, dc, rc, bb, hung, dl);
    n_cmp++;
    if (hung || !cpuid_valid || rdr_err || n_acks != 3) begin
      n_bad++; $display("FAIL rotated_status got hung=%0b valid=%0b err=%0b acks=%0d want 0/1/0/3",
                        hung, cpuid_valid, rdr_err, n_acks);
    end
    n_cmp++;
    if ({cpuid_word0, cpuid_word1, cpuid_word2} !== {W0, W1, W2}) begin
      n_bad++; $display("FAIL rotated_words got=%h %h %h", cpuid_word0, cpuid_word1, cpuid_word2);
    end
    rsp_q.delete();
  endtask

  task automatic test_bad_tag();
    int dc, rc; bit bb, hung, dl;
    max_gap = 0;
    rsp_q = '{W0, 32'h3000_0000, W2};
    collect(1'b0, dc, rc, bb, hung, dl);
    n_cmp++;
    if (hung || {cpuid_valid, rdr_err, rdr_err_code} !== 4'b0101) begin
      n_bad++; $display("FAIL bad_tag_status got hung=%0b %b want 0101", hung, {cpuid_valid, rdr_err, rdr_err_code});
    end
    n_cmp++;
    if (dl || n_acks != 2) begin
      n_bad++; $display("FAIL bad_tag_after got done_long=%0b acks=%0d want 0/2", dl, n_acks);
    end
    rsp_q.delete();
  endtask

  task automatic test_seq_break();
    int dc, rc; bit bb, hung, dl;
    max_gap = 0;
    rsp_q = '{W0, W2, W1};
    collect(1'b0, dc, rc, bb, hung, dl);
    n_cmp++;
    if (hung || {cpuid_valid, rdr_err, rdr_err_code} !== 4'b0110) begin
      n_bad++; $display("FAIL seq_status got hung=%0b %b want 0110", hung, {cpuid_valid, rdr_err, rdr_err_code});
    end
    n_cmp++;
    if (n_acks != 2 || rc != 2 || rsp_q.size() != 1) begin
      n_bad++; $display("FAIL seq_no_third got acks=%0d req_cycles=%0d left=%0d want 2/2/1", n_acks, rc, rsp_q.size());
    end
    rsp_q.delete();
  endtask

  task automatic test_timeout();
    int dc, rc; bit bb, hung, dl;
    rsp_q.delete();
    collect(1'b1, dc, rc, bb, hung, dl);
    n_cmp++;
    if (hung || rc != 16) begin
      n_bad++; $display("FAIL timeout_cycles got hung=%0b req_cycles=%0d want 0/16", hung, rc);
    end
    n_cmp++;
    if ({cpuid_valid, rdr_err, rdr_err_code} !== 4'b0111 || bb || dl) begin
      n_bad++; $display("FAIL timeout_status got %b busy_bad=%0b done_long=%0b want 0111/0/0",
                        {cpuid_valid, rdr_err, rdr_err_code}, bb, dl);
    end
  endtask

  task automatic test_reset_mid();
    int dc, rc; bit bb, hung, dl;
    max_gap = 0; gap_cnt = 0; n_acks = 0;
    rsp_q = '{W0, W1, W2};
    @(posedge regs_clk); #1; rdr_start = 1'b1;
    @(posedge regs_clk); #1; rdr_start = 1'b0;
    @(posedge regs_clk); #1;
    n_cmp++;
    if (cpuid_word0 !== W0 || csr_rd_req !== 1'b1) begin
      n_bad++; $display("FAIL mid_first_ack got word0=%h req=%b want %h/1", cpuid_word0, csr_rd_req, W0);
    end
    cpurst_b = 1'b0;
    @(posedge regs_clk); #1;
    n_cmp++;
    if ({rdr_busy, rdr_done, rdr_err, rdr_err_code, csr_rd_req, cpuid_valid} !== 7'b0 ||
        {cpuid_word0, cpuid_word1, cpuid_word2} !== 96'b0) begin
      n_bad++; $display("FAIL mid_reset got ctrl=%b words=%h %h %h want 0",
                        {rdr_busy, rdr_done, rdr_err, rdr_err_code, csr_rd_req, cpuid_valid},
                        cpuid_word0, cpuid_word1, cpuid_word2);
    end
    cpurst_b = 1'b1;
    rsp_q.delete();
    mdl_word = '{default: '0};
    rsp_q = '{W2, W0, W1};
    collect(1'b0, dc, rc, bb, hung, dl);
    n_cmp++;
    if (hung || !cpuid_valid || rdr_err || {cpuid_word0, cpuid_word1, cpuid_word2} !== {W0, W1, W2}) begin
      n_bad++; $display("FAIL mid_restart got hung=%0b valid=%0b err=%0b words=%h %h %h",
                        hung, cpuid_valid, rdr_err, cpuid_word0, cpuid_word1, cpuid_word2);
    end
    rsp_q.delete();
    mdl_word[0] = W0; mdl_word[1] = W1; mdl_word[2] = W2;
  endtask

  task automatic test_random();
    int dc, rc; bit bb, hung, dl;
    logic [31:0] seq[$];
    logic [1:0]  exp_code;
    int          exp_acks, s, p, kind;
    logic [28:0] exp_fields;
    stray_ack = 1'b1;
    for (int it = 0; it < 40; it++) begin
      seq.delete();
      s = $urandom_range(2, 0);
      for (int k = 0; k < 3; k++) seq.push_back({4'((s + k) % 3), 28'($urandom)});
      kind = $urandom_range(9, 0);
      p = $urandom_range(2, 0);
      if (kind == 6) seq[p][31:28] = 4'($urandom_range(15, 3));
      else if (kind == 7 && p > 0) seq[p][31:28] = 4'((s + p + 1) % 3);
      else if (kind == 8) while (seq.size() > p) void'(seq.pop_back());
      max_gap = $urandom_range(3, 0);
      model_run(seq, exp_code, exp_acks);
      rsp_q = seq;
      collect(1'b1, dc, rc, bb, hung, dl);
      n_cmp++;
      if (hung || rdr_err_code !== exp_code || rdr_err !== (exp_code != 2'b00) ||
          cpuid_valid !== (exp_code == 2'b00)) begin
        n_bad++; $display("FAIL rand%0d_status got hung=%0b code=%b err=%b valid=%b want code=%b",
                          it, hung, rdr_err_code, rdr_err, cpuid_valid, exp_code);
      end
      n_cmp++;
      if (n_acks != exp_acks || bb || dl) begin
        n_bad++; $display("FAIL rand%0d_handshake got acks=%0d busy_bad=%0b done_long=%0b want acks=%0d",
                          it, n_acks, bb, dl, exp_acks);
      end
      n_cmp++;
      if ({cpuid_word0, cpuid_word1, cpuid_word2} !== {mdl_word[0], mdl_word[1], mdl_word[2]}) begin
        n_bad++; $display("FAIL rand%0d_words got=%h %h %h want=%h %h %h", it, cpuid_word0, cpuid_word1,
                          cpuid_word2, mdl_word[0], mdl_word[1], mdl_word[2]);
      end
      if (exp_code == 2'b00) begin
        exp_fields = {2'((mdl_word[0] >> 26) & 3), 4'((mdl_word[0] >> 22) & 15), 4'((mdl_word[0] >> 18) & 15),
                      4'((mdl_word[1] >> 24) & 15), 12'(mdl_word[1] & 12'hFFF), 3'((mdl_word[2] >> 3) & 7)};
        n_cmp++;
        if ({cpuid_arch, cpuid_family, cpuid_class, cpuid_rev, cpuid_product, cpuid_pmp} !== exp_fields) begin
          n_bad++; $display("FAIL rand%0d_fields got=%h want=%h", it,
                            {cpuid_arch, cpuid_family, cpuid_class, cpuid_rev, cpuid_product, cpuid_pmp}, exp_fields);
        end
        if (max_gap == 0) begin
          n_cmp++;
          if (dc != 5) begin n_bad++; $display("FAIL rand%0d_latency got=%0d want=5", it, dc); end
        end
      end
      rsp_q.delete();
    end
    stray_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotated();
    test_bad_tag();
    test_seq_break();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
